// File: rtl/sim_video_pkg.sv
// sim_video_pkg: shared width helpers and default geometry for the sim video output stage
package sim_video_pkg;
    localparam int CENTIPEDE_PIX_DIV = 2;
    localparam int DEF_MAX_H = 512;
    localparam int DEF_MAX_V = 512;

    function automatic int clog2_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // MSB-first bit replication; widths up to 32 bits
    function automatic logic [31:0] expand(input logic [31:0] v, input int in_w, input int out_w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < out_w; k++)
            r[5'(out_w - 1 - k)] = v[5'(in_w - 1 - (k % in_w))];
        return r;
    endfunction
endpackage

// File: rtl/sim_video_measure.sv
// sim_video_measure: pixel coordinates, line/frame geometry capture and frame pulse/counter
module sim_video_measure
    import sim_video_pkg::*;
#(
    parameter int MAX_H = DEF_MAX_H,
    parameter int MAX_V = DEF_MAX_V,
    parameter int FC_W = 16,
    parameter int X_W = clog2_w(MAX_H),
    parameter int Y_W = clog2_w(MAX_V)
) (
    input  logic            clk_12,
    input  logic            reset_n,
    input  logic            ce_i,
    input  logic            hblank_i,
    input  logic            vblank_i,
    output logic [X_W-1:0]  x_o,
    output logic [Y_W-1:0]  y_o,
    output logic            frame_o,
    output logic [FC_W-1:0] frame_count_o,
    output logic [X_W:0]    line_width_o,
    output logic [Y_W:0]    frame_lines_o
);
    localparam logic [X_W-1:0] COL_MAX = X_W'(MAX_H - 1);
    localparam logic [X_W:0]   CNT_MAX = (X_W + 1)'(MAX_H);
    localparam logic [Y_W-1:0] LINE_MAX = Y_W'(MAX_V - 1);

    logic            hb_prev_q, hb_prev_d, vb_prev_q, vb_prev_d, frame_q, frame_d;
    logic [X_W-1:0]  col_q, col_d, x_q, x_d;
    logic [X_W:0]    cnt_q, cnt_d, width_q, width_d;
    logic [Y_W-1:0]  line_q, line_d, y_q, y_d;
    logic [Y_W:0]    lines_q, lines_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic            de, h_rise, v_rise;

    always_comb begin
        de = ~hblank_i & ~vblank_i;
        h_rise = ce_i & hblank_i & ~hb_prev_q;
        v_rise = ce_i & vblank_i & ~vb_prev_q;
        hb_prev_d = ce_i ? hblank_i : hb_prev_q;
        vb_prev_d = ce_i ? vblank_i : vb_prev_q;
        col_d = col_q;
        cnt_d = cnt_q;
        x_d = x_q;
        y_d = y_q;
        line_d = line_q;
        width_d = width_q;
        lines_d = lines_q;
        fc_d = fc_q;
        frame_d = v_rise;
        if (ce_i && de) begin
            x_d = col_q;
            y_d = line_q;
            col_d = (col_q == COL_MAX) ? col_q : col_q + X_W'(1);
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (X_W + 1)'(1);
        end
        if (ce_i && hblank_i) begin
            col_d = '0;
            cnt_d = '0;
        end
        if (h_rise) begin
            width_d = cnt_q;
            if (!vblank_i)
                line_d = (line_q == LINE_MAX) ? line_q : line_q + Y_W'(1);
        end
        // A line ending on the same enable as vblank rises still counts toward the frame
        if (v_rise) begin
            fc_d = fc_q + FC_W'(1);
            lines_d = {1'b0, line_q} + (Y_W + 1)'(h_rise);
            line_d = '0;
        end
    end

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            hb_prev_q <= 1'b0;
            vb_prev_q <= 1'b0;
            frame_q <= 1'b0;
            col_q <= '0;
            cnt_q <= '0;
            x_q <= '0;
            y_q <= '0;
            line_q <= '0;
            width_q <= '0;
            lines_q <= '0;
            fc_q <= '0;
        end else begin
            hb_prev_q <= hb_prev_d;
            vb_prev_q <= vb_prev_d;
            frame_q <= frame_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
            x_q <= x_d;
            y_q <= y_d;
            line_q <= line_d;
            width_q <= width_d;
            lines_q <= lines_d;
            fc_q <= fc_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
    assign frame_o = frame_q;
    assign frame_count_o = fc_q;
    assign line_width_o = width_q;
    assign frame_lines_o = lines_q;
endmodule

// File: rtl/sim_video_out.sv
// sim_video_out: pixel-rate sampler, colour expander and geometry probe between the core and VGA_* ports
module sim_video_out
    import sim_video_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int IN_W = 3,
    parameter int OUT_W = 8,
    parameter int PIX_DIV = CENTIPEDE_PIX_DIV,
    parameter int MAX_H = DEF_MAX_H,
    parameter int MAX_V = DEF_MAX_V,
    parameter int FC_W = 16,
    localparam int X_W = clog2_w(MAX_H),
    localparam int Y_W = clog2_w(MAX_V)
) (
    input  logic                     clk_12,
    input  logic                     reset_n,
    input  logic [CHANNELS*IN_W-1:0] rgb_i,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic                     hblank_i,
    input  logic                     vblank_i,
    output logic [OUT_W-1:0]         VGA_R,
    output logic [OUT_W-1:0]         VGA_G,
    output logic [OUT_W-1:0]         VGA_B,
    output logic                     VGA_HS,
    output logic                     VGA_VS,
    output logic                     VGA_HB,
    output logic                     VGA_VB,
    output logic                     ce_pix_o,
    output logic                     de_o,
    output logic [X_W-1:0]           x_o,
    output logic [Y_W-1:0]           y_o,
    output logic                     frame_o,
    output logic [FC_W-1:0]          frame_count_o,
    output logic [X_W:0]             line_width_o,
    output logic [Y_W:0]             frame_lines_o
);
    localparam int DIV_W = clog2_w(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic               run_q, ce, de, de_q;
    logic [3*OUT_W-1:0] rgb_q, rgb_d;
    logic [3:0]         sync_q;

    // run_q keeps the enable low until the first clock after reset releases
    assign ce = run_q & (div_q == DIV_LAST);
    assign div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    assign de = ~hblank_i & ~vblank_i;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        assign rgb_d[g*OUT_W +: OUT_W] = de ? OUT_W'(expand(32'(rgb_i[g*IN_W +: IN_W]), IN_W, OUT_W)) : '0;
    end

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            run_q <= 1'b0;
            rgb_q <= '0;
            sync_q <= '0;
            de_q <= 1'b0;
        end else begin
            div_q <= div_d;
            run_q <= 1'b1;
            if (ce) begin
                rgb_q <= rgb_d;
                sync_q <= {hsync_i, vsync_i, hblank_i, vblank_i};
                de_q <= de;
            end
        end
    end

    assign {VGA_B, VGA_G, VGA_R} = rgb_q;
    assign {VGA_HS, VGA_VS, VGA_HB, VGA_VB} = sync_q;
    assign ce_pix_o = ce;
    assign de_o = de_q;

    sim_video_measure #(
        .MAX_H(MAX_H),
        .MAX_V(MAX_V),
        .FC_W(FC_W),
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_measure (
        .clk_12(clk_12),
        .reset_n(reset_n),
        .ce_i(ce),
        .hblank_i(hblank_i),
        .vblank_i(vblank_i),
        .x_o(x_o),
        .y_o(y_o),
        .frame_o(frame_o),
        .frame_count_o(frame_count_o),
        .line_width_o(line_width_o),
        .frame_lines_o(frame_lines_o)
    );
endmodule

// File: tb/tb_sim_video_out.sv
// tb_sim_video_out: directed checks of sampling, colour expansion, blanking and geometry measurement
module tb_sim_video_out;
    logic        clk_12 = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  rgb_i = '0;
    logic        hsync_i = 1'b0, vsync_i = 1'b0, hblank_i = 1'b0, vblank_i = 1'b0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_HB, VGA_VB, ce_pix_o, de_o, frame_o;
    logic [8:0]  x_o, y_o;
    logic [15:0] frame_count_o;
    logic [9:0]  line_width_o, frame_lines_o;
    int          n_chk = 0, n_err = 0;

    always #5 clk_12 = ~clk_12;

    sim_video_out dut (
        .clk_12(clk_12), .reset_n(reset_n), .rgb_i(rgb_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_HB(VGA_HB), .VGA_VB(VGA_VB),
        .ce_pix_o(ce_pix_o), .de_o(de_o), .x_o(x_o), .y_o(y_o),
        .frame_o(frame_o), .frame_count_o(frame_count_o),
        .line_width_o(line_width_o), .frame_lines_o(frame_lines_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // Present one pixel on the next enable and return 1ns after it has been sampled
    task automatic pix(input logic hs, input logic vs, input logic hb, input logic vb, input logic [8:0] rgb);
        int n = 0;
        @(negedge clk_12);
        while (!ce_pix_o && n < 8) begin
            @(negedge clk_12);
            n++;
        end
        if (!ce_pix_o) chk("ce_timeout", 32'(ce_pix_o), 1);
        {hsync_i, vsync_i, hblank_i, vblank_i, rgb_i} = {hs, vs, hb, vb, rgb};
        @(posedge clk_12);
        #1;
    endtask

    task automatic line(input int na, input int nb, input int y_exp);
        for (int i = 0; i < na; i++) begin
            pix(1'b0, 1'b0, 1'b0, 1'b0, 9'(i));
            if (i == 0) begin
                chk("line_y", 32'(y_o), y_exp);
                chk("line_x0", 32'(x_o), 0);
            end
        end
        for (int i = 0; i < nb; i++) pix(1'b1, 1'b0, 1'b1, 1'b0, 9'd0);
    endtask

    task automatic vrise(input int fc, input int lines);
        pix(1'b0, 1'b1, 1'b1, 1'b1, 9'd0);
        chk("frame_pulse", 32'(frame_o), 1);
        chk("frame_count", 32'(frame_count_o), fc);
        chk("frame_lines", 32'(frame_lines_o), lines);
        @(posedge clk_12);
        #1;
        chk("frame_pulse_end", 32'(frame_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_12);
        chk("rst_ce", 32'(ce_pix_o), 0);
        chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
        chk("rst_sync", 32'({VGA_HS, VGA_VS, VGA_HB, VGA_VB, de_o, frame_o}), 0);
        chk("rst_xy", 32'({x_o, y_o}), 0);
        chk("rst_fc", 32'(frame_count_o), 0);
        chk("rst_meas", 32'({line_width_o, frame_lines_o}), 0);
        reset_n = 1'b1;
        #1 chk("ce_seq0", 32'(ce_pix_o), 0);
        @(posedge clk_12); #1 chk("ce_seq1", 32'(ce_pix_o), 1);
        @(posedge clk_12); #1 chk("ce_seq2", 32'(ce_pix_o), 0);
        @(posedge clk_12); #1 chk("ce_seq3", 32'(ce_pix_o), 1);

        // The enable at the second clock sampled an all-zero active pixel, so this one is column 1
        pix(1'b1, 1'b0, 1'b0, 1'b0, 9'b001_101_110);
        chk("exp_r", 32'(VGA_R), 32'hDB);
        chk("exp_g", 32'(VGA_G), 32'hB6);
        chk("exp_b", 32'(VGA_B), 32'h24);
        chk("exp_de", 32'(de_o), 1);
        chk("exp_hs", 32'({VGA_HS, VGA_HB}), 32'b10);
        chk("exp_x", 32'(x_o), 1);
        pix(1'b0, 1'b0, 1'b1, 1'b0, 9'b001_101_110);
        chk("blank_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
        chk("blank_de", 32'({de_o, VGA_HB}), 32'b01);
        chk("blank_width", 32'(line_width_o), 2);
        vrise(1, 1);
        chk("vb_pass", 32'({VGA_VS, VGA_VB}), 32'b11);
        repeat (2) pix(1'b0, 1'b1, 1'b1, 1'b1, 9'd0);

        for (int i = 0; i < 256; i++) begin
            pix(1'b0, 1'b0, 1'b0, 1'b0, 9'(i));
            chk("full_x", 32'(x_o), i);
            if (i == 0) chk("full_y", 32'(y_o), 0);
        end
        pix(1'b1, 1'b0, 1'b1, 1'b0, 9'd0);
        chk("width_256", 32'(line_width_o), 256);
        repeat (31) pix(1'b1, 1'b0, 1'b1, 1'b0, 9'd0);
        for (int l = 1; l < 240; l++) line(8, 4, l);
        chk("last_y", 32'(y_o), 239);
        chk("last_x", 32'(x_o), 7);
        chk("width_8", 32'(line_width_o), 8);
        vrise(2, 240);
        repeat (2) pix(1'b0, 1'b1, 1'b1, 1'b1, 9'd0);

        for (int i = 0; i < 600; i++) begin
            pix(1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
            if (i == 0) chk("sat_y", 32'(y_o), 0);
            if (i == 511) chk("sat_x511", 32'(x_o), 511);
            if (i == 599) chk("sat_x599", 32'(x_o), 511);
        end
        pix(1'b1, 1'b0, 1'b1, 1'b0, 9'd0);
        chk("width_sat", 32'(line_width_o), 512);
        repeat (3) pix(1'b1, 1'b0, 1'b1, 1'b0, 9'd0);
        for (int l = 1; l < 10; l++) line(8, 4, l);
        line(8, 0, 10);
        vrise(3, 11);
        repeat (2) pix(1'b0, 1'b1, 1'b1, 1'b1, 9'd0);
        pix(1'b0, 1'b0, 1'b0, 1'b0, 9'h1FF);
        chk("clear_y", 32'(y_o), 0);
        repeat (3) pix(1'b0, 1'b0, 1'b0, 1'b0, 9'h1FF);
        chk("pre_rst_r", 32'(VGA_R), 32'hFF);
        chk("pre_rst_x", 32'(x_o), 3);

        @(negedge clk_12);
        reset_n = 1'b0;
        #1;
        chk("arst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
        chk("arst_x", 32'(x_o), 0);
        chk("arst_fc", 32'(frame_count_o), 0);
        chk("arst_meas", 32'({line_width_o, frame_lines_o}), 0);
        chk("arst_de_ce", 32'({de_o, ce_pix_o}), 0);
        repeat (3) @(negedge clk_12);
        reset_n = 1'b1;
        #1 chk("post_rst_fc", 32'(frame_count_o), 0);
        line(5, 3, 0);
        chk("post_width", 32'(line_width_o), 5);
        line(5, 3, 1);
        vrise(1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
